// File: rtl/md_pkg.sv
// Shared state encoding, request record and defaults for the multdiv issue controller.
package md_pkg;

    localparam int MD_RD_W           = 5;
    localparam int MD_TIMEOUT_CYCLES = 80;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        BUSY,
        DRAIN,
        WB
    } md_state_e;

    typedef struct packed {
        logic        is_div;
        logic [31:0] op_a;
        logic [15:0] op_b;
    } md_req_t;

endpackage

// File: rtl/md_watchdog.sv
// Cycle counter for BUSY/DRAIN; raises hit once LIMIT cycles have elapsed and
// keeps a sticky error flag that only reset clears.
module md_watchdog #(
    parameter int LIMIT = 80
) (
    input  logic clock,
    input  logic rst_n,
    input  logic run,
    output logic hit,
    output logic err
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Saturates at LIMIT-1 so a flush on the hit cycle still times out in DRAIN.
    assign hit = run && (cnt >= CW'(LIMIT - 1));

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (!run)
                cnt <= '0;
            else if (!hit)
                cnt <= cnt + 1'b1;
            if (hit)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/multdiv_issue.sv
// Issue controller between execute and the external multdiv unit: launch, stall, writeback.
// Optional BUSY/DRAIN watchdog enabled by defining MD_TIMEOUT_EN.
module multdiv_issue
    import md_pkg::*;
#(
    parameter int RD_W           = MD_RD_W,
    parameter int TIMEOUT_CYCLES = MD_TIMEOUT_CYCLES
) (
    input  logic            clock,
    input  logic            ctrl_reset,
    input  logic            issue_valid,
    input  logic            issue_is_div,
    input  logic [31:0]     issue_opA,
    input  logic [15:0]     issue_opB,
    input  logic [RD_W-1:0] issue_rd,
    input  logic            flush,
    output logic            issue_ready,
    output logic            stall,
    output logic            ctrl_MULT,
    output logic            ctrl_DIV,
    output logic [31:0]     data_operandA,
    output logic [15:0]     data_operandB,
    input  logic            data_inputRDY,
    input  logic            data_resultRDY,
    input  logic [31:0]     data_result,
    input  logic            data_exception,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            wb_exception,
    output logic            timeout_err
);

    md_state_e       state_q, state_d;
    md_req_t         req_q;
    logic [RD_W-1:0] rd_q;
    logic            armed_q;
    logic            accept, rdy_ok, tmo_hit, capture;

    assign accept = (state_q == IDLE) && issue_valid && !flush;
    // armed_q masks the first BUSY cycle so a stale resultRDY is not taken.
    assign rdy_ok = armed_q && data_resultRDY;

`ifdef MD_TIMEOUT_EN
    md_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clock (clock),
        .rst_n (ctrl_reset),
        .run   ((state_q == BUSY) || (state_q == DRAIN)),
        .hit   (tmo_hit),
        .err   (timeout_err)
    );
`else
    logic unused_tmo;
    assign unused_tmo  = (TIMEOUT_CYCLES > 0);
    assign tmo_hit     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     if (flush) state_d = IDLE;
                     else if (data_inputRDY) state_d = BUSY;
            BUSY:    if (rdy_ok) state_d = flush ? IDLE : WB;
                     else if (flush) state_d = DRAIN;
                     else if (tmo_hit) state_d = WB;
            DRAIN:   if (rdy_ok || tmo_hit) state_d = IDLE;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign capture = (state_q == BUSY) && (state_d == WB);

    always_ff @(posedge clock or negedge ctrl_reset) begin
        if (!ctrl_reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            rd_q         <= '0;
            armed_q      <= 1'b0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= (state_q == BUSY) || (state_q == DRAIN);
            if (accept) begin
                req_q <= '{is_div: issue_is_div, op_a: issue_opA, op_b: issue_opB};
                rd_q  <= issue_rd;
            end
            // A watchdog-forced writeback reports an exception with zero data.
            if (capture) begin
                wb_data      <= rdy_ok ? data_result : '0;
                wb_exception <= rdy_ok ? data_exception : 1'b1;
            end
        end
    end

    assign issue_ready   = (state_q == IDLE);
    assign stall         = (state_q == REQ) || (state_q == BUSY) || (state_q == DRAIN) || accept;
    // flush drops the ctrl line combinationally so no launch can slip through.
    assign ctrl_MULT     = (state_q == REQ) && !flush && (req_q.is_div == OP_MULT);
    assign ctrl_DIV      = (state_q == REQ) && !flush && (req_q.is_div == OP_DIV);
    assign data_operandA = req_q.op_a;
    assign data_operandB = req_q.op_b;
    assign wb_valid      = (state_q == WB);
    assign wb_rd         = rd_q;

endmodule

// File: doc/multdiv_issue.md
Name: multdiv_issue

Overview:
- Initiator-side controller that drives the multdiv unit on behalf of the execute stage.
- Accepts one MULT/DIV request and launches it with the ctrl_MULT/ctrl_DIV + data_inputRDY handshake.
- Holds the pipeline stalled until data_resultRDY, then presents a one-cycle writeback (result, destination reg, exception flag).
- Sits between execute and writeback; multdiv is an external instance.

Parameters:
- RD_W, 5, destination register index width
- TIMEOUT_CYCLES, 80, max cycles BUSY may wait for data_resultRDY (only with MD_TIMEOUT_EN)

Ports:
- clock  in  1  system clock, rising edge
- ctrl_reset  in  1  asynchronous active-low reset (0 = reset)
- issue_valid  in  1  request present
- issue_is_div  in  1  1 = DIV, 0 = MULT
- issue_opA  in  32  signed operand A
- issue_opB  in  16  signed operand B
- issue_rd  in  RD_W  destination register
- flush  in  1  kill in-flight op, no writeback
- issue_ready  out  1  high only in IDLE
- stall  out  1  pipeline stall
- ctrl_MULT  out  1  to multdiv
- ctrl_DIV  out  1  to multdiv
- data_operandA  out  32  to multdiv
- data_operandB  out  16  to multdiv
- data_inputRDY  in  1  from multdiv
- data_resultRDY  in  1  from multdiv
- data_result  in  32  from multdiv
- data_exception  in  1  from multdiv
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  RD_W  writeback register
- wb_data  out  32  result
- wb_exception  out  1  overflow/DIV0 flag
- timeout_err  out  1  sticky watchdog flag (MD_TIMEOUT_EN only, else tied 0)

Behaviour:
- Reset (async, ctrl_reset=0): state IDLE; every output 0 except issue_ready=1; operand/rd registers cleared; timeout counter 0.
- States: IDLE, REQ, BUSY, DRAIN, WB.
- IDLE: issue_valid=1 and flush=0 -> latch opA/opB/rd/is_div, go to REQ. Operands are driven from the latch and stay stable until leaving BUSY/DRAIN.
- REQ: assert exactly one of ctrl_MULT/ctrl_DIV (per is_div) while waiting.
  - On a cycle with data_inputRDY=1, the ctrl line is sampled as the launch; next cycle drop ctrl, go to BUSY.
  - Launch-to-BUSY latency is 1 cycle minimum.
- BUSY: wait for data_resultRDY=1.
  - Capture data_result into wb_data and data_exception into wb_exception, go to WB.
  - A resultRDY visible in the same cycle the ctrl is dropped is ignored (stale); counting starts the cycle after launch.
- WB: wb_valid=1 for exactly one cycle; wb_rd = latched rd; then IDLE.
- stall = 1 in REQ, BUSY, DRAIN and IDLE-with-accept. stall = 0 in the WB cycle, so the dependent instruction may proceed as wb_valid is seen.
- issue_ready = (state==IDLE). Requests arriving outside IDLE are ignored; the upstream holds them via stall.
- Flush:
  - In REQ before launch: drop ctrl, go to IDLE.
  - In BUSY: go to DRAIN; wait data_resultRDY, discard result, then IDLE. No wb_valid.
  - In WB: ignored (writeback completes).
  - flush and issue_valid together in IDLE: flush wins, no accept.
- Exception: wb_exception mirrors data_exception sampled with resultRDY. DIV by 0 must yield wb_exception=1 regardless of wb_data.
- Reset mid-operation: state returns to IDLE immediately; multdiv (no reset) may still complete, and the first resultRDY after reset with no launch is ignored.

Optional Feature:
- MD_TIMEOUT_EN defined:
  - Counter increments each cycle in BUSY/DRAIN.
  - Reaching TIMEOUT_CYCLES sets sticky timeout_err, forces wb_valid with wb_exception=1, wb_data=0 (from BUSY) or IDLE (from DRAIN).
  - timeout_err clears only on reset.
- MD_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; timeout_err tied 0.

Decomposition:
- Shared package md_pkg: state encoding enum (IDLE, REQ, BUSY, DRAIN, WB), OP_MULT/OP_DIV constants, RD_W default, TIMEOUT_CYCLES default.
- No sub-module needed; optional sub-module md_watchdog for the timeout counter.

Test Plan:
- MULT 7 x -3, rd=5, multdiv stub with 8-cycle latency -> one ctrl_MULT pulse after inputRDY, stall high throughout, wb_valid one cycle, wb_data=-21, wb_rd=5, wb_exception=0.
- DIV 100 / 7, rd=9, 66-cycle stub -> ctrl_DIV only, wb_data=14, stall drops exactly on the wb_valid cycle.
- DIV 1234 / 0 -> wb_valid with wb_exception=1; next issue accepted in the following cycle.
- Issue DIV, flush 10 cycles after launch -> no wb_valid, stall held until stub resultRDY, issue_ready returns one cycle after.
- Reset pulse (ctrl_reset=0 for 2 cycles) mid-BUSY -> all outputs 0, issue_ready=1; subsequent stray resultRDY does not produce wb_valid.
- MD_TIMEOUT_EN with stub never raising resultRDY -> after 80 BUSY cycles timeout_err=1, wb_valid with wb_exception=1, wb_data=0.
